rx_5g_pkt_fifo: RTL and testbench
=================================

Name: rx_5g_pkt_fifo

Overview:
- Receive packet buffer directly downstream of the 2.5G/5G XGMII rate-control stage.
- Captures the 64-bit data / 8-bit control words qualified by that stage's write enable, and the per-packet byte count qualified by its byte-count write enable.
- Exposes complete packets only, as a byte-count queue plus a committed data queue, to the receive MAC read logic.
- Packets that cannot be fully stored are discarded atomically by rewinding the write pointer.

Parameters:
DATA_AW, 9, data FIFO address width (depth 2^DATA_AW words of 72 bits: ctrl[71:64], data[63:0])
BCNT_AW, 4, byte-count FIFO address width (depth 2^BCNT_AW entries of 16 bits)

Ports:
clk  in  1  156 MHz clock
reset_  in  1  asynchronous active-low reset
en  in  1  mode_2p5G | mode_5G; writes accepted only while high
wr_data  in  64  data from rate-control stage
wr_ctrl  in  8  control from rate-control stage
wr_we  in  1  data write enable (we_5g)
wr_bcnt  in  16  packet byte count; [15] = SOF-on-byte-4 flag
wr_bcnt_we  in  1  byte-count write enable (x_bcnt_we)
pkt_avail  out  1  byte-count FIFO not empty
pkt_bcnt  out  16  head byte count (valid while pkt_avail)
bcnt_pop  in  1  pop head byte count
rd_en  in  1  read one committed data word
rd_valid  out  1  rd_data/rd_ctrl valid
rd_data  out  64  read data
rd_ctrl  out  8  read control
drop_cnt  out  16  dropped-packet counter, saturating at 16'hFFFF
data_used  out  DATA_AW+1  committed words held

Behaviour:
Reset and reset timing:
- Asynchronous assert, synchronous release.
- On reset: all pointers 0, state IDLE, pkt_avail 0, rd_valid 0, rd_data 0, rd_ctrl 0, drop_cnt 0, data_used 0.
- Reset mid-packet discards everything, including committed data.

Pointers:
- Pointers are DATA_AW+1 bits wide: wr_ptr, cmt_ptr, rd_ptr.
- full = (wr_ptr - rd_ptr) == 2^DATA_AW.
- data_used = cmt_ptr - rd_ptr, using modular arithmetic.

SOF detect:
- A word is an SOF word when wr_we is high and either (wr_ctrl[0] and wr_data[7:0]==8'hFB) or (wr_ctrl[4] and wr_data[39:32]==8'hFB).

Write FSM (IDLE, PKT, DROP):
- IDLE
  - SOF word: write it at wr_ptr, go to PKT.
  - Non-SOF wr_we: ignored.
  - wr_bcnt_we: ignored; no drop counted.
- PKT
  - wr_we and not full: write, wr_ptr+1.
  - wr_we and full: wr_ptr <= cmt_ptr, drop_cnt+1, go to DROP.
  - SOF word (previous packet never got its count): wr_ptr rewinds to cmt_ptr, the word is written at cmt_ptr, wr_ptr <= cmt_ptr+1, drop_cnt+1, stay in PKT.
  - wr_bcnt_we with byte-count FIFO not full: push wr_bcnt; cmt_ptr <= wr_ptr, or wr_ptr+1 if a word is also written that cycle; go to IDLE.
  - wr_bcnt_we with byte-count FIFO full: wr_ptr <= cmt_ptr, drop_cnt+1, go to IDLE.
- DROP
  - Non-SOF wr_we: ignored.
  - wr_bcnt_we: go to IDLE, no extra count.
  - SOF word: handled as in IDLE.
- en low: state <= IDLE, wr_ptr <= cmt_ptr. An in-progress packet is dropped and counted if the state was PKT.

Read side:
- rd_en with data_used != 0: rd_data/rd_ctrl come from RAM[rd_ptr] with 1-cycle latency; rd_valid is high the next cycle; rd_ptr+1.
- rd_en with data_used == 0: ignored; rd_valid stays 0.
- Uncommitted words are never readable.
- bcnt_pop with pkt_avail: advance the byte-count read pointer. bcnt_pop on empty: ignored.
- The reader is responsible for reading ceil((bcnt[14:0] + 4*bcnt[15]) / 8) words per packet. The FIFO does not check this.

Simultaneous events:
- Write and read in the same cycle are both honoured.
- A commit and a read in the same cycle: data_used reflects both the next cycle.
- A push and a pop of the byte-count FIFO in the same cycle are both honoured; the full test uses pre-pop occupancy.

Counter:
- drop_cnt saturates at 16'hFFFF.

Memory:
- Inferred simple dual-port RAMs, write-first not required.

Test Plan:
- Single packet: SOF 8'hFB at byte 0, 8 words, then wr_bcnt=16'h003C with wr_bcnt_we -> pkt_avail=1, pkt_bcnt=16'h003C, data_used=8; 8 rd_en read back identical words with rd_valid one cycle after each rd_en; drop_cnt=0.
- SOF on byte 4, wr_bcnt=16'h8040 -> pkt_bcnt=16'h8040; data_used is 0 until the commit cycle, then equals the words written.
- Overflow: DATA_AW=4 (16 words), hold reads, send a 20-word packet -> packet discarded, data_used unchanged, drop_cnt=1; the next 4-word packet commits normally.
- Byte-count FIFO full: BCNT_AW=1, push 2 packets without popping, send a 3rd -> 3rd discarded, drop_cnt=1; pop one count, send a 4th -> accepted.
- Orphan SOF: 3 words of packet A, then an SOF for packet B without wr_bcnt_we, 5 words, then commit -> data_used=5, drop_cnt=1, read data equals packet B.
- en deasserted mid-packet, then an asynchronous reset pulse mid-packet -> first drops the packet (drop_cnt+1, data_used unchanged); reset clears all outputs immediately regardless of clk.

Source files
------------

// File: rtl/rx_5g_pkt_fifo.sv
// Receive packet FIFO behind the 2.5G/5G rate-control stage: stores whole
// packets, exposes a committed data queue plus a per-packet byte-count queue,
// and discards packets that cannot be stored by rewinding the write pointer.
module rx_5g_pkt_fifo #(
    parameter int unsigned DATA_AW = 9,
    parameter int unsigned BCNT_AW = 4
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               en,
    input  logic [63:0]        wr_data,
    input  logic [7:0]         wr_ctrl,
    input  logic               wr_we,
    input  logic [15:0]        wr_bcnt,
    input  logic               wr_bcnt_we,
    output logic               pkt_avail,
    output logic [15:0]        pkt_bcnt,
    input  logic               bcnt_pop,
    input  logic               rd_en,
    output logic               rd_valid,
    output logic [63:0]        rd_data,
    output logic [7:0]         rd_ctrl,
    output logic [15:0]        drop_cnt,
    output logic [DATA_AW:0]   data_used
);

    localparam int unsigned PW     = DATA_AW + 1;
    localparam int unsigned DEPTH  = 2 ** DATA_AW;
    localparam int unsigned BPW    = BCNT_AW + 1;
    localparam int unsigned BDEPTH = 2 ** BCNT_AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PKT  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               rst_n;
    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BPW-1:0]     bwr_q, bwr_d, brd_q, brd_d;
    logic               pkt_avail_q, pkt_avail_d, rd_valid_q, rd_valid_d;
    logic [15:0]        pkt_bcnt_q, pkt_bcnt_d, drop_cnt_q, drop_cnt_d;
    logic [63:0]        rd_data_q, rd_data_d;
    logic [7:0]         rd_ctrl_q, rd_ctrl_d;
    logic [DATA_AW:0]   data_used_q, data_used_d;

    logic [71:0]        mem [DEPTH];
    logic [15:0]        bmem [BDEPTH];
    logic               mem_we, bpush, bpop, drop_inc, sof, full, cmt_full, bcnt_full, rd_fire;
    logic [DATA_AW-1:0] mem_waddr;
    logic [71:0]        rd_word;

    // Reset: asynchronous assertion, release synchronised to clk.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) rst_sync_q <= '0;
        else         rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // Occupancy flags and start-of-frame detection.
    always_comb begin
        sof       = wr_we && ((wr_ctrl[0] && (wr_data[7:0] == 8'hFB)) ||
                              (wr_ctrl[4] && (wr_data[39:32] == 8'hFB)));
        full      = PW'(wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
        cmt_full  = PW'(cmt_ptr_q - rd_ptr_q) == PW'(DEPTH);
        bcnt_full = BPW'(bwr_q - brd_q) == BPW'(BDEPTH);
    end

    // Write FSM: accumulate a packet, commit on byte count, rewind on failure.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q[DATA_AW-1:0];
        bpush     = 1'b0;
        drop_inc  = 1'b0;
        if (!en) begin
            state_d  = S_IDLE;
            wr_ptr_d = cmt_ptr_q;
            drop_inc = (state_q == S_PKT);
        end else begin
            case (state_q)
                S_PKT: begin
                    if (sof) begin
                        // Orphaned packet: drop it and restart at the commit point.
                        drop_inc = 1'b1;
                        if (cmt_full) begin
                            wr_ptr_d = cmt_ptr_q;
                            state_d  = S_DROP;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = cmt_ptr_q[DATA_AW-1:0];
                            wr_ptr_d  = cmt_ptr_q + PW'(1);
                        end
                    end else if (wr_we && full) begin
                        wr_ptr_d = cmt_ptr_q;
                        drop_inc = 1'b1;
                        state_d  = S_DROP;
                    end else begin
                        if (wr_we) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end
                        if (wr_bcnt_we) begin
                            state_d = S_IDLE;
                            if (!bcnt_full) begin
                                bpush     = 1'b1;
                                cmt_ptr_d = wr_ptr_d;
                            end else begin
                                wr_ptr_d = cmt_ptr_q;
                                drop_inc = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and DROP wait for the next SOF; wr_ptr equals cmt_ptr here.
                    if (sof) begin
                        if (cmt_full) begin
                            drop_inc = 1'b1;
                            state_d  = S_DROP;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            state_d  = S_PKT;
                        end
                    end else if (wr_bcnt_we) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
        drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    // Read side, byte-count queue and occupancy.
    always_comb begin
        rd_fire     = rd_en && (cmt_ptr_q != rd_ptr_q);
        rd_ptr_d    = rd_ptr_q + PW'(rd_fire);
        rd_valid_d  = rd_fire;
        rd_word     = mem[rd_ptr_q[DATA_AW-1:0]];
        rd_data_d   = rd_fire ? rd_word[63:0]  : rd_data_q;
        rd_ctrl_d   = rd_fire ? rd_word[71:64] : rd_ctrl_q;
        bpop        = bcnt_pop && (bwr_q != brd_q);
        bwr_d       = bwr_q + BPW'(bpush);
        brd_d       = brd_q + BPW'(bpop);
        pkt_avail_d = (bwr_d != brd_d);
        pkt_bcnt_d  = (bpush && (bwr_q[BCNT_AW-1:0] == brd_d[BCNT_AW-1:0])) ?
                      wr_bcnt : bmem[brd_d[BCNT_AW-1:0]];
        data_used_d = cmt_ptr_d - rd_ptr_d;
    end

    // Data and byte-count storage.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= {wr_ctrl, wr_data};
        if (bpush)  bmem[bwr_q[BCNT_AW-1:0]] <= wr_bcnt;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            bwr_q       <= '0;
            brd_q       <= '0;
            pkt_avail_q <= 1'b0;
            pkt_bcnt_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_ctrl_q   <= '0;
            drop_cnt_q  <= '0;
            data_used_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bwr_q       <= bwr_d;
            brd_q       <= brd_d;
            pkt_avail_q <= pkt_avail_d;
            pkt_bcnt_q  <= pkt_bcnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_ctrl_q   <= rd_ctrl_d;
            drop_cnt_q  <= drop_cnt_d;
            data_used_q <= data_used_d;
        end
    end

    assign pkt_avail = pkt_avail_q;
    assign pkt_bcnt  = pkt_bcnt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_ctrl   = rd_ctrl_q;
    assign drop_cnt  = drop_cnt_q;
    assign data_used = data_used_q;

endmodule

// File: tb/tb_rx_5g_pkt_fifo.sv
// Bench for rx_5g_pkt_fifo: queue-based packet model compared every cycle,
// plus directed packet scenarios with hand-computed expectations.
module tb_rx_5g_pkt_fifo;

    localparam int unsigned DATA_AW = 4;
    localparam int unsigned BCNT_AW = 1;
    localparam int          DDEPTH  = 16;
    localparam int          BDEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset_ = 1'b0;
    logic              en = 1'b0;
    logic [63:0]       wr_data = '0;
    logic [7:0]        wr_ctrl = '0;
    logic              wr_we = 1'b0;
    logic [15:0]       wr_bcnt = '0;
    logic              wr_bcnt_we = 1'b0;
    logic              pkt_avail;
    logic [15:0]       pkt_bcnt;
    logic              bcnt_pop = 1'b0;
    logic              rd_en = 1'b0;
    logic              rd_valid;
    logic [63:0]       rd_data;
    logic [7:0]        rd_ctrl;
    logic [15:0]       drop_cnt;
    logic [DATA_AW:0]  data_used;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    rx_5g_pkt_fifo #(.DATA_AW(DATA_AW), .BCNT_AW(BCNT_AW)) dut (
        .clk(clk), .reset_(reset_), .en(en),
        .wr_data(wr_data), .wr_ctrl(wr_ctrl), .wr_we(wr_we),
        .wr_bcnt(wr_bcnt), .wr_bcnt_we(wr_bcnt_we),
        .pkt_avail(pkt_avail), .pkt_bcnt(pkt_bcnt), .bcnt_pop(bcnt_pop),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ctrl(rd_ctrl),
        .drop_cnt(drop_cnt), .data_used(data_used)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Packet-level model: pending words, committed words, byte counts.
    logic [71:0] m_cq[$];
    logic [71:0] m_pend[$];
    logic [15:0] m_bq[$];
    bit          m_in, m_valid, m_full, m_bfull, m_fire, m_pop, m_sof, m_was;
    int          m_drop, m_cq_pre;
    logic [71:0] m_word;

    task automatic bump();
        if (m_drop < 65535) m_drop++;
    endtask

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_cq.delete(); m_pend.delete(); m_bq.delete();
            m_in = 1'b0; m_valid = 1'b0; m_drop = 0; m_word = '0;
        end else begin
            m_cq_pre = m_cq.size();
            m_fire   = rd_en && (m_cq_pre > 0);
            m_full   = (m_cq_pre + m_pend.size()) == DDEPTH;
            m_bfull  = m_bq.size() == BDEPTH;
            m_pop    = bcnt_pop && (m_bq.size() > 0);
            m_sof    = wr_we && ((wr_ctrl[0] && wr_data[7:0] == 8'hFB) ||
                                 (wr_ctrl[4] && wr_data[39:32] == 8'hFB));
            m_valid  = m_fire;
            if (m_fire) m_word = m_cq.pop_front();
            if (!en) begin
                if (m_in) bump();
                m_in = 1'b0;
                m_pend.delete();
            end else if (m_sof) begin
                m_was = m_in;
                if (m_in) bump();
                m_pend.delete();
                m_in = 1'b0;
                if (m_cq_pre == DDEPTH) begin
                    if (!m_was) bump();
                end else begin
                    m_pend.push_back({wr_ctrl, wr_data});
                    m_in = 1'b1;
                end
            end else if (m_in) begin
                if (wr_we && m_full) begin
                    bump();
                    m_in = 1'b0;
                    m_pend.delete();
                end else begin
                    if (wr_we) m_pend.push_back({wr_ctrl, wr_data});
                    if (wr_bcnt_we) begin
                        if (!m_bfull) begin
                            foreach (m_pend[k]) m_cq.push_back(m_pend[k]);
                            m_bq.push_back(wr_bcnt);
                        end else begin
                            bump();
                        end
                        m_pend.delete();
                        m_in = 1'b0;
                    end
                end
            end
            if (m_pop) void'(m_bq.pop_front());
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("pkt_avail", 64'(pkt_avail), 64'(m_bq.size() > 0));
            if (m_bq.size() > 0) cmp("pkt_bcnt", 64'(pkt_bcnt), 64'(m_bq[0]));
            cmp("data_used", 64'(data_used), 64'(m_cq.size()));
            cmp("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            cmp("rd_valid", 64'(rd_valid), 64'(m_valid));
            if (m_valid) begin
                cmp("rd_data", rd_data, m_word[63:0]);
                cmp("rd_ctrl", 64'(rd_ctrl), 64'(m_word[71:64]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wd(input int tag, input int i);
        return {8'(tag), 8'(i), 48'h0011_2233_4455};
    endfunction

    function automatic logic [63:0] sof_word(input int tag, input bit pos4);
        logic [63:0] d;
        d = wd(tag, 0);
        if (pos4) d[39:32] = 8'hFB;
        else      d[7:0]   = 8'hFB;
        return d;
    endfunction

    task automatic send_pkt(input int tag, input int n, input bit pos4, input bit commit,
                            input bit with_last, input logic [15:0] bc);
        for (int i = 0; i < n; i++) begin
            wr_we = 1'b1;
            if (i == 0) begin
                wr_ctrl = pos4 ? 8'h10 : 8'h01;
                wr_data = sof_word(tag, pos4);
            end else begin
                wr_ctrl = 8'h00;
                wr_data = wd(tag, i);
            end
            if (commit && with_last && (i == n - 1)) begin
                wr_bcnt    = bc;
                wr_bcnt_we = 1'b1;
            end
            tick();
            wr_we = 1'b0; wr_bcnt_we = 1'b0; wr_ctrl = '0; wr_data = '0;
        end
        if (commit && !with_last) begin
            wr_bcnt = bc; wr_bcnt_we = 1'b1;
            tick();
            wr_bcnt_we = 1'b0;
        end
    endtask

    task automatic rd_words(input int n, input bit pop);
        rd_en = 1'b1; bcnt_pop = pop;
        tick();
        bcnt_pop = 1'b0;
        for (int i = 1; i < n; i++) tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk_on = 1'b1;
        reset_ = 1'b1;
        repeat (4) tick();
        en = 1'b1;
        tick();
        cmp("rst_pkt_avail", 64'(pkt_avail), 64'd0);
        cmp("rst_rd_valid",  64'(rd_valid),  64'd0);
        cmp("rst_rd_data",   rd_data,        64'd0);
        cmp("rst_data_used", 64'(data_used), 64'd0);
        cmp("rst_drop_cnt",  64'(drop_cnt),  64'd0);

        // Single packet, SOF on byte 0.
        send_pkt(1, 8, 1'b0, 1'b1, 1'b0, 16'h003C);
        cmp("t1_pkt_avail", 64'(pkt_avail), 64'd1);
        cmp("t1_pkt_bcnt",  64'(pkt_bcnt),  64'h003C);
        cmp("t1_data_used", 64'(data_used), 64'd8);
        rd_en = 1'b1; bcnt_pop = 1'b1;
        tick();
        bcnt_pop = 1'b0;
        cmp("t1_rd_valid", 64'(rd_valid), 64'd1);
        cmp("t1_rd_data0", rd_data, 64'h0100_0011_2233_44FB);
        cmp("t1_rd_ctrl0", 64'(rd_ctrl), 64'h01);
        repeat (7) tick();
        rd_en = 1'b0;
        tick();
        cmp("t1_drained", 64'(data_used), 64'd0);
        cmp("t1_drop_cnt", 64'(drop_cnt), 64'd0);

        // SOF on byte 4: nothing visible until the commit.
        send_pkt(2, 5, 1'b1, 1'b0, 1'b0, 16'h0000);
        cmp("t2_precommit_used", 64'(data_used), 64'd0);
        wr_bcnt = 16'h8040; wr_bcnt_we = 1'b1;
        tick();
        wr_bcnt_we = 1'b0;
        cmp("t2_pkt_bcnt",  64'(pkt_bcnt),  64'h8040);
        cmp("t2_data_used", 64'(data_used), 64'd5);
        rd_words(5, 1'b1);

        // Data overflow: 20-word packet into a 16-word FIFO.
        send_pkt(3, 20, 1'b0, 1'b1, 1'b0, 16'h00A0);
        cmp("t3_drop_cnt",  64'(drop_cnt),  64'd1);
        cmp("t3_data_used", 64'(data_used), 64'd0);
        cmp("t3_pkt_avail", 64'(pkt_avail), 64'd0);
        send_pkt(4, 4, 1'b0, 1'b1, 1'b0, 16'h0020);
        cmp("t3_next_used", 64'(data_used), 64'd4);
        rd_words(4, 1'b1);

        // Byte-count FIFO full.
        send_pkt(5, 4, 1'b0, 1'b1, 1'b0, 16'h0020);
        send_pkt(6, 4, 1'b0, 1'b1, 1'b0, 16'h001F);
        send_pkt(7, 4, 1'b0, 1'b1, 1'b0, 16'h001E);
        cmp("t4_drop_cnt",  64'(drop_cnt),  64'd2);
        cmp("t4_data_used", 64'(data_used), 64'd8);
        rd_words(4, 1'b1);
        send_pkt(8, 4, 1'b0, 1'b1, 1'b0, 16'h001D);
        cmp("t4_accept_used", 64'(data_used), 64'd8);
        cmp("t4_accept_drop", 64'(drop_cnt),  64'd2);
        cmp("t4_head_bcnt",   64'(pkt_bcnt),  64'h001F);
        rd_words(4, 1'b1);
        rd_words(4, 1'b1);

        // Orphan SOF: packet A abandoned by packet B's SOF.
        send_pkt(9, 3, 1'b0, 1'b0, 1'b0, 16'h0000);
        send_pkt(10, 5, 1'b0, 1'b1, 1'b0, 16'h0028);
        cmp("t5_data_used", 64'(data_used), 64'd5);
        cmp("t5_drop_cnt",  64'(drop_cnt),  64'd3);
        rd_en = 1'b1; bcnt_pop = 1'b1;
        tick();
        bcnt_pop = 1'b0;
        cmp("t5_rd_data0", rd_data, 64'h0A00_0011_2233_44FB);
        repeat (4) tick();
        rd_en = 1'b0;
        tick();

        // Reads overlapping a packet whose commit rides on its last word.
        send_pkt(11, 8, 1'b0, 1'b1, 1'b0, 16'h0040);
        rd_en = 1'b1;
        send_pkt(12, 5, 1'b0, 1'b1, 1'b1, 16'h0025);
        repeat (9) tick();
        rd_en = 1'b0;
        bcnt_pop = 1'b1;
        tick(); tick();
        bcnt_pop = 1'b0;
        tick();
        cmp("t6_data_used", 64'(data_used), 64'd0);
        cmp("t6_pkt_avail", 64'(pkt_avail), 64'd0);

        // en dropped mid-packet, then asynchronous reset mid-packet.
        send_pkt(13, 2, 1'b0, 1'b1, 1'b0, 16'h0010);
        send_pkt(14, 3, 1'b0, 1'b0, 1'b0, 16'h0000);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        cmp("t7_en_drop", 64'(drop_cnt),  64'd4);
        cmp("t7_en_used", 64'(data_used), 64'd2);
        send_pkt(15, 2, 1'b0, 1'b0, 1'b0, 16'h0000);
        #2;
        reset_ = 1'b0;
        #1;
        cmp("t7_rst_pkt_avail", 64'(pkt_avail), 64'd0);
        cmp("t7_rst_data_used", 64'(data_used), 64'd0);
        cmp("t7_rst_drop_cnt",  64'(drop_cnt),  64'd0);
        cmp("t7_rst_rd_valid",  64'(rd_valid),  64'd0);
        cmp("t7_rst_rd_data",   rd_data,        64'd0);
        cmp("t7_rst_rd_ctrl",   64'(rd_ctrl),   64'd0);
        tick();
        reset_ = 1'b1;
        repeat (4) tick();

        // Normal operation after reset.
        send_pkt(16, 3, 1'b0, 1'b1, 1'b0, 16'h0018);
        cmp("t8_data_used", 64'(data_used), 64'd3);
        cmp("t8_pkt_bcnt",  64'(pkt_bcnt),  64'h0018);
        rd_words(3, 1'b1);
        cmp("t8_drained", 64'(data_used), 64'd0);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
